// File: rtl/robot_pkg.sv
// rtl/robot_pkg.sv - shared types and default constants for the robot controller
//
// Purpose: controller state encoding, heading encoding and parameter defaults
//          used by robot_controller and its testbench.
// Ports:   none (package).
package robot_pkg;

  typedef enum logic [2:0] {
    SEARCH,
    FOLLOW,
    ADVANCE,
    ROT_RIGHT,
    REMOVING,
    STOP
  } state_t;

  // Heading encoding; one `turn` rotates N->W->S->E->N.
  typedef enum logic [1:0] {
    DIR_NORTH = 2'b00,
    DIR_SOUTH = 2'b01,
    DIR_EAST  = 2'b10,
    DIR_WEST  = 2'b11
  } dir_t;

  localparam int REMOVE_CYCLES_DEF = 3;
  localparam int MAX_TURNS_DEF     = 8;

  // A right rotation is built from three left turns.
  localparam int ROT_RIGHT_TURNS   = 3;

endpackage

// File: rtl/robot_controller.sv
// rtl/robot_controller.sv - left-wall-following maze robot controller
//
// Purpose: wall follower with trash removal, exit detection and stuck
//          detection. All outputs are registered; the action chosen from
//          the sensors at one rising edge appears on the outputs after it.
// Config:  TRASH_REMOVAL_EN - when defined, `barrier` starts a REMOVING
//          sequence; when undefined, `barrier` behaves like `head` and
//          `remove` is tied low.
// Ports:
//   clock    in   robot clock, rising edge active
//   reset    in   synchronous active-high reset
//   head     in   wall/edge directly ahead
//   left     in   wall/edge directly to the left
//   under    in   standing on the exit cell
//   barrier  in   trash cell directly ahead
//   front    out  move one cell forward
//   turn     out  rotate 90 degrees left
//   remove   out  trash-removal strobe
//   halted   out  stopped permanently (exit or stuck)
module robot_controller
  import robot_pkg::*;
#(
  parameter int REMOVE_CYCLES = REMOVE_CYCLES_DEF,
  parameter int MAX_TURNS     = MAX_TURNS_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic head,
  input  logic left,
  input  logic under,
  input  logic barrier,
  output logic front,
  output logic turn,
  output logic remove,
  output logic halted
);

  localparam int                TURN_W     = $clog2(MAX_TURNS + 1);
  localparam logic [TURN_W-1:0] TURN_LIMIT = TURN_W'(MAX_TURNS);
  localparam logic [1:0]        ROT_LAST   = 2'(ROT_RIGHT_TURNS - 1);

  state_t            state;
  state_t            next_state;
  logic [TURN_W-1:0] turn_cnt;
  logic [1:0]        rot_cnt;
  logic              act_front;
  logic              act_turn;
  logic              blocked;      // cannot step forward
  logic              follow_hold;  // FOLLOW is leaving without a move/turn
  logic              stuck;

`ifdef TRASH_REMOVAL_EN
  localparam int               REM_W    = $clog2(REMOVE_CYCLES + 1);
  localparam logic [REM_W-1:0] REM_LAST = REM_W'(REMOVE_CYCLES - 1);

  logic [REM_W-1:0] rem_cnt;
  logic             act_remove;

  assign blocked     = head;
  assign follow_hold = under | barrier;
`else
  // Without removal hardware, trash is just another wall.
  assign blocked     = head | barrier;
  assign follow_hold = under;
  assign remove      = 1'b0;
`endif

  assign stuck = (turn_cnt == TURN_LIMIT);

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= SEARCH;
    else       state <= next_state;
  end

  // Next-state logic; the stuck condition overrides every other transition.
  always_comb begin
    next_state = state;
    if (stuck) begin
      next_state = STOP;
    end else begin
      case (state)
        SEARCH:    if (blocked) next_state = ROT_RIGHT;
        ROT_RIGHT: if (rot_cnt == ROT_LAST) next_state = FOLLOW;
        FOLLOW: begin
          if (under) next_state = STOP;
`ifdef TRASH_REMOVAL_EN
          else if (barrier) next_state = REMOVING;
`endif
          else if (!left)   next_state = ADVANCE;
          else if (blocked) next_state = ROT_RIGHT;
        end
        ADVANCE:   next_state = FOLLOW;
`ifdef TRASH_REMOVAL_EN
        REMOVING:  if (rem_cnt == REM_LAST) next_state = FOLLOW;
`endif
        STOP:      next_state = STOP;
        default:   next_state = SEARCH;
      endcase
    end
  end

  // Action decode; at most one action is ever selected.
  always_comb begin
    act_front = 1'b0;
    act_turn  = 1'b0;
`ifdef TRASH_REMOVAL_EN
    act_remove = 1'b0;
`endif
    if (!stuck) begin
      case (state)
        SEARCH:    act_front = !blocked;
        ROT_RIGHT: act_turn  = 1'b1;
        FOLLOW: begin
          if (!follow_hold) begin
            if (!left) act_turn  = 1'b1;
            else       act_front = !blocked;
          end
        end
        // One step after a left turn so open space cannot spin us forever.
        ADVANCE:   act_front = !blocked;
`ifdef TRASH_REMOVAL_EN
        REMOVING:  act_remove = 1'b1;
`endif
        default: ;
      endcase
    end
  end

  // Registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      front  <= 1'b0;
      turn   <= 1'b0;
      halted <= 1'b0;
    end else begin
      front  <= act_front;
      turn   <= act_turn;
      halted <= (next_state == STOP);
    end
  end

  // Turn counter (saturating, cleared by forward motion) and rotation step
  always_ff @(posedge clock) begin
    if (reset) begin
      turn_cnt <= '0;
      rot_cnt  <= '0;
    end else begin
      if (act_front)
        turn_cnt <= '0;
      else if (act_turn && turn_cnt != TURN_LIMIT)
        turn_cnt <= turn_cnt + 1'b1;
      if (state == ROT_RIGHT && next_state == ROT_RIGHT)
        rot_cnt <= rot_cnt + 2'd1;
      else
        rot_cnt <= '0;
    end
  end

`ifdef TRASH_REMOVAL_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      remove  <= 1'b0;
      rem_cnt <= '0;
    end else begin
      remove <= act_remove;
      if (state == REMOVING && next_state == REMOVING)
        rem_cnt <= rem_cnt + 1'b1;
      else
        rem_cnt <= '0;
    end
  end
`endif

endmodule
